// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory and its byte-stream loader.
// Holds the loader FSM encoding, the default memory depth and the range check helper.
package imem_loader_pkg;

   localparam int unsigned MEM_DEPTH_DEFAULT = 1025;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StLoad  = 2'd1,
      StWrite = 2'd2,
      StDone  = 2'd3
   } state_t;

   // True when [base, base+n) does not fit in a memory of 'depth' words; 33-bit, never wraps.
   function automatic logic range_err(input logic [31:0] base, input logic [10:0] n,
                                      input int unsigned depth);
      logic [32:0] last_excl;
      last_excl = {1'b0, base} + {22'd0, n};
      return last_excl > {1'b0, depth};
   endfunction

endpackage

// File: rtl/imem_loader.sv
// Loads big-endian instruction words from a byte stream into an external instruction memory
// write port, with a range check at start and a running checksum of the written words.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] base_addr,
   input  logic [10:0] num_words,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] checksum
);

   state_t      state;
   logic [31:0] addr;
   logic [10:0] remaining;
   logic [1:0]  byte_cnt;
   // First three bytes of the word in flight; the fourth goes straight into mem_wdata.
   logic [23:0] shreg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= StIdle;
         addr      <= '0;
         remaining <= '0;
         byte_cnt  <= '0;
         shreg     <= '0;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         checksum  <= '0;
      end else begin
         // Strobes are high only in the cycle after the transition that sets them.
         mem_we <= 1'b0;
         done   <= 1'b0;

         unique case (state)
            StIdle: begin
               if (start) begin
                  addr      <= base_addr;
                  remaining <= num_words;
                  checksum  <= '0;
                  byte_cnt  <= '0;
                  error     <= 1'b0;
                  busy      <= 1'b1;
                  if (num_words == 11'd0) begin
                     state <= StDone;
                     done  <= 1'b1;
                  end else if (range_err(base_addr, num_words, MEM_DEPTH)) begin
                     error <= 1'b1;
                     state <= StDone;
                     done  <= 1'b1;
                  end else begin
                     state    <= StLoad;
                     in_ready <= 1'b1;
                  end
               end
            end

            StLoad: begin
               if (in_valid) begin
                  case (byte_cnt)
                     2'd0:    shreg[23:16] <= in_data;
                     2'd1:    shreg[15:8]  <= in_data;
                     2'd2:    shreg[7:0]   <= in_data;
                     default: ;
                  endcase
                  if (byte_cnt == 2'd3) begin
                     mem_wdata <= {shreg, in_data};
                     mem_addr  <= addr;
                     mem_we    <= 1'b1;
                     in_ready  <= 1'b0;
                     byte_cnt  <= '0;
                     state     <= StWrite;
                  end else begin
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end
            end

            StWrite: begin
               checksum  <= checksum + mem_wdata;
               addr      <= addr + 32'd1;
               remaining <= remaining - 11'd1;
               if (remaining == 11'd1) begin
                  state <= StDone;
                  done  <= 1'b1;
               end else begin
                  state    <= StLoad;
                  in_ready <= 1'b1;
               end
            end

            StDone: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed plus randomized loads of imem_loader checked against a word-level reference model.
module tb_imem_loader;

   localparam int unsigned DEPTH = 1025;
   localparam int          BUDGET = 400;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] base_addr;
   logic [10:0] num_words;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] checksum;

   imem_loader dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .num_words (num_words),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .checksum  (checksum)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_mis = 0;
   logic [7:0]  src[$];
   logic [63:0] wr_q[$];
   int          done_cnt = 0;

   // Passive observer of the memory write port and completion pulses.
   always @(negedge clk) begin
      if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_wdata});
      if (done === 1'b1) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input int i);
      return {src[4*i], src[4*i+1], src[4*i+2], src[4*i+3]};
   endfunction

   // mode 0: in_valid always high, 1: toggles every cycle, 2: random.
   task automatic do_load(input string tag, input logic [31:0] base, input int n, input int mode,
                          input bit preset, input bit restart);
      int          nb;
      int          idx;
      int          cyc;
      int          widx;
      int          n_exp;
      bit          pend;
      bit          acc;
      bit          err;
      logic [31:0] sum;
      logic [63:0] e;
      nb = 4 * n;
      if (!preset) begin
         src.delete();
         for (int i = 0; i < nb; i++) src.push_back(8'($urandom));
      end
      err   = (n != 0) && ((64'(base) + 64'(n)) > 64'(DEPTH));
      n_exp = err ? 0 : n;
      sum   = '0;
      for (int i = 0; i < n_exp; i++) sum += model_word(i);

      wr_q.delete();
      done_cnt = 0;
      @(negedge clk);
      start     = 1'b1;
      base_addr = base;
      num_words = 11'(n);
      @(negedge clk);
      start     = 1'b0;
      base_addr = $urandom;
      num_words = 11'($urandom);

      idx  = 0;
      cyc  = 0;
      widx = 0;
      pend = 1'b0;
      while (n_exp > 0 && (idx < nb || pend) && cyc < BUDGET) begin
         if (pend) begin
            check({tag, "_we_latency"}, 32'(mem_we), 32'd1);
            check({tag, "_addr"}, mem_addr, base + 32'(widx));
            check({tag, "_data"}, mem_wdata, model_word(widx));
            widx++;
            pend = 1'b0;
         end
         if (restart) begin
            start     = (cyc == 2);
            base_addr = 32'd999;
            num_words = 11'd3;
         end
         case (mode)
            0:       in_valid = (idx < nb);
            1:       in_valid = (idx < nb) && cyc[0];
            default: in_valid = (idx < nb) && ($urandom_range(0, 1) == 1);
         endcase
         in_data = (idx < nb) ? src[idx] : 8'h00;
         acc = in_valid && (in_ready === 1'b1);
         @(posedge clk);
         if (acc) begin
            idx++;
            if (idx % 4 == 0) pend = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      repeat (6) @(negedge clk);

      check({tag, "_timeout"}, 32'(cyc >= BUDGET), 32'd0);
      check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(n_exp));
      for (int i = 0; i < wr_q.size() && i < n_exp; i++) begin
         e = wr_q[i];
         check({tag, "_mon_addr"}, e[63:32], base + 32'(i));
         check({tag, "_mon_data"}, e[31:0], model_word(i));
      end
      check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
      check({tag, "_checksum"}, checksum, sum);
      check({tag, "_error"}, 32'(error), 32'(err));
      check({tag, "_busy_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      num_words = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_checksum", checksum, 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Known two-word program.
      src = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
      do_load("vec", 32'd0, 2, 0, 1'b1, 1'b0);
      check("vec_checksum_const", checksum, 32'hAC11_0009);

      do_load("zero", 32'd7, 0, 0, 1'b0, 1'b0);
      do_load("over", 32'd1024, 2, 0, 1'b0, 1'b0);
      do_load("wrap", 32'hFFFF_FFFF, 2, 0, 1'b0, 1'b0);
      do_load("fit_end", 32'd1023, 2, 2, 1'b0, 1'b0);
      do_load("last_word", 32'd1024, 1, 0, 1'b0, 1'b0);
      do_load("toggle", 32'd40, 1, 1, 1'b0, 1'b0);
      do_load("restart", 32'd100, 2, 0, 1'b0, 1'b1);

      // Abort after two bytes of the first word.
      @(negedge clk);
      start     = 1'b1;
      base_addr = 32'd5;
      num_words = 11'd1;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hAA;
      @(negedge clk);
      in_data = 8'hBB;
      @(negedge clk);
      in_valid = 1'b0;
      wr_q.delete();
      reset = 1'b1;
      #1;
      check("abort_in_ready", 32'(in_ready), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_mem_addr", mem_addr, 32'd0);
      check("abort_mem_wdata", mem_wdata, 32'd0);
      check("abort_checksum", checksum, 32'd0);
      repeat (2) @(negedge clk);
      check("abort_no_write", 32'(wr_q.size()), 32'd0);
      reset = 1'b0;
      do_load("after_abort", 32'd5, 1, 0, 1'b0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         do_load("rand", 32'($urandom_range(0, 1030)), int'($urandom_range(0, 6)), 2, 1'b0,
                 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
